mpeg2_stream_parser: RTL and testbench

MPEG2_STREAM_PARSER -- requirements
Module: mpeg2_stream_parser

---
 rtl/mpeg2_stream_parser_pkg.sv | 25 ++
 rtl/mpeg2_stream_parser_if.sv | 15 +
 rtl/mpeg2_beat_fifo.sv | 49 ++++
 rtl/mpeg2_stream_parser.sv | 173 +++++++++++++++++
 tb/tb_mpeg2_stream_parser.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpeg2_stream_parser_pkg.sv
// Shared constants for the MPEG-2 stream parser: start codes, prefix, parser states.
package mpeg2_stream_parser_pkg;

  localparam logic [7:0]  SC_SEQ_HDR   = 8'hB3;
  localparam logic [7:0]  SC_PICTURE   = 8'h00;
  localparam logic [7:0]  SC_SEQ_END   = 8'hB7;
  localparam logic [23:0] START_PREFIX = 24'h000001;

  localparam int unsigned BEAT_BYTES = 32;
  localparam int unsigned BEAT_W     = 257;
  localparam logic [4:0]  LAST_IDX   = 5'd31;

  typedef enum logic [2:0] {
    SCAN,
    CODE,
    HDR1,
    HDR2,
    HDR3
  } pstate_e;

  function automatic logic [7:0] beat_byte(input logic [255:0] d, input logic [4:0] k);
    return d[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mpeg2_stream_parser_if.sv
// Beat input and byte output handshake of the MPEG-2 stream parser.
interface mpeg2_stream_parser_if;
  logic         i_en;
  logic         i_last;
  logic [255:0] i_data;
  logic         i_bready;
  logic         o_bvalid;
  logic [7:0]   o_byte;
  logic         o_blast;

  modport master (output i_en, i_last, i_data, i_bready,
                  input  o_bvalid, o_byte, o_blast);
  modport slave  (input  i_en, i_last, i_data, i_bready,
                  output o_bvalid, o_byte, o_blast);
endinterface

// File: rtl/mpeg2_beat_fifo.sv
// Synchronous beat FIFO; exposes head and the entry behind it so the
// serializer can cross beat boundaries without a bubble.
module mpeg2_beat_fifo #(
  parameter int unsigned AW = 2,
  parameter int unsigned W  = 257
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic [W-1:0] nx_data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         multi_o
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_q, rd_q, cnt;
  logic [AW-1:0] rd_nx;
  logic          push, pop;

  assign cnt       = wr_q - rd_q;
  assign full_o    = cnt[AW];
  assign empty_o   = (cnt == '0);
  assign multi_o   = (cnt > (AW+1)'(1));
  assign push      = wr_en_i & ~full_o;
  assign pop       = rd_en_i & ~empty_o;
  assign rd_nx     = rd_q[AW-1:0] + AW'(1);
  assign rd_data_o = mem_q[rd_q[AW-1:0]];
  assign nx_data_o = mem_q[rd_nx];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/mpeg2_stream_parser.sv
// Buffers 256-bit stream beats, serializes them to bytes and extracts
// sequence-header sizes, picture count and sequence-end events.
module mpeg2_stream_parser
  import mpeg2_stream_parser_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  mpeg2_stream_parser_if.slave  strm,
  output logic [11:0]           o_xsize,
  output logic [11:0]           o_ysize,
  output logic                  o_size_valid,
  output logic [15:0]           o_pic_count,
  output logic                  o_seq_end,
  output logic                  o_overflow
);

  logic [BEAT_W-1:0] head, nxt, src;
  logic              full, empty, multi;

  logic       bvalid_q, bvalid_d;
  logic [7:0] byte_q, byte_d;
  logic       blast_q, blast_d;
  logic [4:0] idx_q, idx_d;
  logic       xfer, adv, load_ok;

  pstate_e     st_q;
  logic [1:0]  zc_q;
  logic [11:0] hx_q;
  logic [3:0]  hy_q;
  logic [11:0] xsize_q, ysize_q;
  logic        size_valid_q, seq_end_q, ovf_q;
  logic [15:0] pic_q;
  logic        prefix;

  assign xfer = bvalid_q & strm.i_bready;
  assign adv  = ~bvalid_q | strm.i_bready;

  mpeg2_beat_fifo #(
    .AW (FIFO_AW),
    .W  (BEAT_W)
  ) u_fifo (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .wr_en_i   (strm.i_en),
    .wr_data_i ({strm.i_last, strm.i_data}),
    .rd_en_i   (xfer && (idx_q == LAST_IDX)),
    .rd_data_o (head),
    .nx_data_o (nxt),
    .full_o    (full),
    .empty_o   (empty),
    .multi_o   (multi)
  );

  // idx_q names the byte held in the output register; the head beat stays in
  // the FIFO until its byte 31 transfers, so byte 0 of the next beat comes
  // from the entry behind the head.
  always_comb begin
    bvalid_d = bvalid_q;
    byte_d   = byte_q;
    blast_d  = blast_q;
    idx_d    = idx_q;
    src      = head;
    load_ok  = 1'b0;
    if (adv) begin
      if (bvalid_q && idx_q != LAST_IDX) begin
        idx_d   = idx_q + 5'd1;
        load_ok = 1'b1;
      end else if (bvalid_q) begin
        idx_d   = '0;
        src     = nxt;
        load_ok = multi;
      end else begin
        idx_d   = '0;
        load_ok = ~empty;
      end
      bvalid_d = load_ok;
      byte_d   = load_ok ? beat_byte(src[255:0], idx_d) : '0;
      blast_d  = load_ok & src[256] & (idx_d == LAST_IDX);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bvalid_q <= 1'b0;
      byte_q   <= '0;
      blast_q  <= 1'b0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      bvalid_q <= bvalid_d;
      byte_q   <= byte_d;
      blast_q  <= blast_d;
      idx_q    <= idx_d;
      if (strm.i_en && full) ovf_q <= 1'b1;
    end
  end

  assign prefix = (zc_q == 2'd2) && (byte_q == START_PREFIX[7:0]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q         <= SCAN;
      zc_q         <= '0;
      hx_q         <= '0;
      hy_q         <= '0;
      xsize_q      <= '0;
      ysize_q      <= '0;
      size_valid_q <= 1'b0;
      seq_end_q    <= 1'b0;
      pic_q        <= '0;
    end else begin
      seq_end_q <= 1'b0;
      if (xfer) begin
        if (byte_q == START_PREFIX[23:16])
          zc_q <= (zc_q == 2'd2) ? 2'd2 : zc_q + 2'd1;
        else
          zc_q <= '0;
        case (st_q)
          SCAN: if (prefix) st_q <= CODE;
          CODE: begin
            st_q <= SCAN;
            if (byte_q == SC_SEQ_HDR) st_q <= HDR1;
            if (byte_q == SC_PICTURE) pic_q <= pic_q + 16'd1;
            if (byte_q == SC_SEQ_END) seq_end_q <= 1'b1;
          end
          HDR1: begin
            if (prefix) st_q <= CODE;
            else begin
              hx_q[11:4] <= byte_q;
              st_q       <= HDR2;
            end
          end
          HDR2: begin
            if (prefix) st_q <= CODE;
            else begin
              hx_q[3:0] <= byte_q[7:4];
              hy_q      <= byte_q[3:0];
              st_q      <= HDR3;
            end
          end
          HDR3: begin
            if (prefix) st_q <= CODE;
            else begin
              xsize_q      <= hx_q;
              ysize_q      <= {hy_q, byte_q};
              size_valid_q <= 1'b1;
              st_q         <= SCAN;
            end
          end
          default: st_q <= SCAN;
        endcase
        // The last byte of a sequence still counts, but nothing carries past it.
        if (blast_q) begin
          st_q <= SCAN;
          zc_q <= '0;
        end
      end
    end
  end

  assign strm.o_bvalid = bvalid_q;
  assign strm.o_byte   = byte_q;
  assign strm.o_blast  = blast_q;
  assign o_xsize       = xsize_q;
  assign o_ysize       = ysize_q;
  assign o_size_valid  = size_valid_q;
  assign o_pic_count   = pic_q;
  assign o_seq_end     = seq_end_q;
  assign o_overflow    = ovf_q;

endmodule

// File: tb/tb_mpeg2_stream_parser.sv
// Scoreboard bench for mpeg2_stream_parser: expected bytes are queued at
// stimulus time; a monitor pops them on each transfer and feeds a byte-level model.
module tb_mpeg2_stream_parser;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] o_xsize, o_ysize;
  logic        o_size_valid, o_seq_end, o_overflow;
  logic [15:0] o_pic_count;

  mpeg2_stream_parser_if bus();

  mpeg2_stream_parser #(.FIFO_AW(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .strm         (bus),
    .o_xsize      (o_xsize),
    .o_ysize      (o_ysize),
    .o_size_valid (o_size_valid),
    .o_pic_count  (o_pic_count),
    .o_seq_end    (o_seq_end),
    .o_overflow   (o_overflow)
  );

  initial forever #5 clk = ~clk;

  int unsigned checks = 0, errors = 0;
  logic [8:0]  expq [$];
  int unsigned n_xfer = 0, dut_se = 0;
  bit          rnd_ready = 0;
  logic        ready_level = 1'b1;
  logic        hold_v = 1'b0;
  logic [8:0]  hold_val;

  // Reference model: history of the last two bytes plus position within a code/header.
  bit          z1, z2;
  int unsigned m_mode;
  logic [7:0]  m_hdr [3];
  logic [11:0] m_x, m_y;
  logic        m_sv, m_ovf;
  logic [15:0] m_pic;
  int unsigned m_se;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    z1 = 0; z2 = 0; m_mode = 0;
    m_x = '0; m_y = '0; m_sv = 1'b0; m_ovf = 1'b0; m_pic = '0; m_se = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic last);
    bit hit;
    hit = z1 && z2 && (b == 8'h01);
    if (m_mode == 0) begin
      if (hit) m_mode = 1;
    end else if (m_mode == 1) begin
      m_mode = 0;
      if (b == 8'hB3) m_mode = 2;
      else if (b == 8'h00) m_pic = m_pic + 16'd1;
      else if (b == 8'hB7) m_se++;
    end else begin
      if (hit) m_mode = 1;
      else begin
        m_hdr[m_mode-2] = b;
        if (m_mode == 4) begin
          m_x = {m_hdr[0], m_hdr[1][7:4]};
          m_y = {m_hdr[1][3:0], b};
          m_sv = 1'b1;
          m_mode = 0;
        end else m_mode++;
      end
    end
    z2 = z1;
    z1 = (b == 8'h00);
    if (last) begin
      m_mode = 0; z1 = 0; z2 = 0;
    end
  endtask

  // Monitor
  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    if (rstn) begin
      if (hold_v) begin
        chk("hold_valid", 32'(bus.o_bvalid), 32'd1);
        chk("hold_data", 32'({bus.o_blast, bus.o_byte}), 32'(hold_val));
      end
      if (bus.o_bvalid && bus.i_bready) begin
        n_xfer++;
        chk("unexpected_byte", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("byte_stream", 32'({bus.o_blast, bus.o_byte}), 32'(e));
          model_byte(e[7:0], e[8]);
        end
      end
      hold_v   = bus.o_bvalid && !bus.i_bready;
      hold_val = {bus.o_blast, bus.o_byte};
      if (o_seq_end) dut_se++;
    end else hold_v = 1'b0;
  end

  // Sole driver of i_bready
  initial begin
    bus.i_bready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) bus.i_bready = 1'($urandom_range(0, 1));
      else           bus.i_bready = ready_level;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic step(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_beat(input logic [7:0] b [32], input logic last, input bit store);
    logic [255:0] d;
    for (int k = 0; k < 32; k++) begin
      d[8*k +: 8] = b[k];
      if (store) expq.push_back({last && (k == 31), b[k]});
    end
    bus.i_data = d;
    bus.i_last = last;
    bus.i_en   = 1'b1;
    @(posedge clk); #1;
    bus.i_en   = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && expq.size() != 0; i++) step(1);
    chk("drain_remaining", 32'(expq.size()), 32'd0);
    expq.delete();
    step(4);
  endtask

  task automatic status(input string tag);
    chk({tag, "_pic_count"}, 32'(o_pic_count), 32'(m_pic));
    chk({tag, "_xsize"}, 32'(o_xsize), 32'(m_x));
    chk({tag, "_ysize"}, 32'(o_ysize), 32'(m_y));
    chk({tag, "_size_valid"}, 32'(o_size_valid), 32'(m_sv));
    chk({tag, "_overflow"}, 32'(o_overflow), 32'(m_ovf));
    chk({tag, "_seq_end_cycles"}, dut_se, m_se);
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_bvalid"}, 32'(bus.o_bvalid), 32'd0);
    chk({tag, "_byte"}, 32'(bus.o_byte), 32'd0);
    chk({tag, "_blast"}, 32'(bus.o_blast), 32'd0);
    chk({tag, "_seq_end"}, 32'(o_seq_end), 32'd0);
    chk({tag, "_size_valid"}, 32'(o_size_valid), 32'd0);
    chk({tag, "_overflow"}, 32'(o_overflow), 32'd0);
    chk({tag, "_xsize"}, 32'(o_xsize), 32'd0);
    chk({tag, "_ysize"}, 32'(o_ysize), 32'd0);
    chk({tag, "_pic_count"}, 32'(o_pic_count), 32'd0);
  endtask

  function automatic logic [7:0] pick();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r <= 2) return 8'h00;
    if (r == 3) return 8'h01;
    if (r == 4) return 8'hB3;
    if (r == 5) return 8'hB7;
    return 8'($urandom);
  endfunction

  initial begin
    logic [7:0]  bb [32];
    int unsigned n0;

    model_reset();
    bus.i_en = 1'b0; bus.i_last = 1'b0; bus.i_data = '0;
    rstn = 1'b0;
    step(3);
    reset_values("por");
    rstn = 1'b1;
    step(2);

    // Sequence header 288x208, with first-byte latency
    for (int k = 0; k < 32; k++) bb[k] = 8'hFF;
    bb[0] = 8'h00; bb[1] = 8'h00; bb[2] = 8'h01; bb[3] = 8'hB3;
    bb[4] = 8'h12; bb[5] = 8'h00; bb[6] = 8'hD0;
    send_beat(bb, 1'b0, 1'b1);
    chk("latency_cycle1_bvalid", 32'(bus.o_bvalid), 32'd0);
    step(1);
    chk("latency_cycle2_bvalid", 32'(bus.o_bvalid), 32'd1);
    chk("latency_cycle2_byte0", 32'(bus.o_byte), 32'h00);
    wait_drain();
    status("hdr");
    chk("hdr_xsize_288", 32'(o_xsize), 32'd288);
    chk("hdr_ysize_208", 32'(o_ysize), 32'd208);
    chk("hdr_size_valid", 32'(o_size_valid), 32'd1);

    // Three picture codes, one prefix split across beats
    for (int k = 0; k < 32; k++) bb[k] = 8'hFF;
    bb[0] = 8'h00; bb[1] = 8'h00; bb[2] = 8'h00; bb[3] = 8'h01; bb[4] = 8'h00;
    bb[29] = 8'h00; bb[30] = 8'h00; bb[31] = 8'h00;
    send_beat(bb, 1'b0, 1'b1);
    for (int k = 0; k < 32; k++) bb[k] = 8'hFF;
    bb[0] = 8'h01; bb[1] = 8'h00;
    bb[10] = 8'h00; bb[11] = 8'h00; bb[12] = 8'h00; bb[13] = 8'h01; bb[14] = 8'h00;
    send_beat(bb, 1'b0, 1'b1);
    wait_drain();
    status("pic");
    chk("pic_count_3", 32'(o_pic_count), 32'd3);

    // Sequence end pulse
    for (int k = 0; k < 32; k++) bb[k] = 8'hFF;
    bb[0] = 8'h00; bb[1] = 8'h00; bb[2] = 8'h01; bb[3] = 8'hB7;
    send_beat(bb, 1'b0, 1'b1);
    wait_drain();
    status("seqend");
    chk("seqend_single_cycle", dut_se, 32'd1);

    // Random backpressure, 8 beats, last flagged on beat 8
    rnd_ready = 1;
    for (int bt = 1; bt <= 8; bt++) begin
      for (int i = 0; i < 2000 && expq.size() > 64; i++) step(1);
      step($urandom_range(0, 3));
      for (int k = 0; k < 32; k++) bb[k] = pick();
      send_beat(bb, bt == 8, 1'b1);
    end
    wait_drain();
    rnd_ready = 0;
    step(2);
    status("rand");

    // Reset in the middle of a beat
    for (int k = 0; k < 32; k++) bb[k] = 8'(8'h40 + k);
    send_beat(bb, 1'b0, 1'b1);
    step(6);
    rstn = 1'b0;
    #1;
    reset_values("midrst");
    expq.delete();
    model_reset();
    dut_se = 0;
    step(2);
    rstn = 1'b1;
    step(2);
    for (int k = 0; k < 32; k++) bb[k] = 8'(8'h80 + k);
    send_beat(bb, 1'b0, 1'b1);
    wait_drain();
    status("postrst");

    // Overflow: six back-to-back beats with the sink stalled
    ready_level = 1'b0;
    step(2);
    for (int bt = 0; bt < 6; bt++) begin
      for (int k = 0; k < 32; k++) bb[k] = pick();
      send_beat(bb, 1'b0, bt < 4);
    end
    step(3);
    chk("overflow_set", 32'(o_overflow), 32'd1);
    m_ovf = 1'b1;
    n0 = n_xfer;
    ready_level = 1'b1;
    wait_drain();
    step(10);
    chk("overflow_bytes_out", n_xfer - n0, 32'd128);
    status("ovf");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
